qr_encode: RTL and testbench

Byte-mode QR version-1 (21×21, EC level L) data-codeword encoder and module placer. Accepts a payload byte stream and builds the 152-bit data-codeword bitstream: mode, length, payload, terminator, and 0xEC/0x11 pads. It writes that bitstream one bit per cycle into a 441-bit unmasked module grid. It is the inverse of `decode`: its `qr_out` fed to `decode.qr_unmasked` must recover mode, length and payload. Masking, EC codewords and function patterns are added downstream.

---
 rtl/qr_pkg.sv | 20 ++
 rtl/qr_place_cursor.sv | 75 +++++++
 rtl/qr_encode.sv | 132 +++++++++++++
 tb/tb_qr_encode.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/qr_pkg.sv
// rtl/qr_pkg.sv - shared constants and state type for the QR v1-L data encoder
package qr_pkg;

  localparam int MOD_SIZE    = 21;
  localparam int MAX_PAYLOAD = 17;
  localparam int DATA_BITS   = 152;
  localparam int GRID_BITS   = MOD_SIZE * MOD_SIZE;

  localparam logic [3:0] MODE_BYTE = 4'b0100;
  localparam logic [7:0] PAD0      = 8'hEC;
  localparam logic [7:0] PAD1      = 8'h11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_PLACE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/qr_place_cursor.sv
// rtl/qr_place_cursor.sv - walks the data-module placement path of a 21x21 grid
module qr_place_cursor
  import qr_pkg::*;
(
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       start,
  input  logic       step,
  output logic [8:0] idx_out,
  output logic       last_out
);

  // Pair 0 is columns (20,19); each pair moves two columns left.
  logic [2:0] r_pair;
  logic [4:0] r_row;
  logic       r_lo;

  logic       w_up;
  logic       w_full;
  logic [4:0] w_j_hi;
  logic [4:0] w_col;
  logic [4:0] w_row_end;
  logic [4:0] w_row_next;
  logic [4:0] w_next_start;

  // Even pairs climb from row 0, odd pairs descend; the last two pairs span the
  // taller region and hop over row 14.
  assign w_up     = ~r_pair[0];
  assign w_full   = r_pair[2];
  assign w_j_hi   = 5'd20 - {1'b0, r_pair, 1'b0};
  assign w_col    = r_lo ? (w_j_hi - 5'd1) : w_j_hi;
  assign idx_out  = 9'(r_row) + 9'(w_col) * 9'd21;
  assign last_out = (r_pair == 3'd5) && (r_row == 5'd12) && r_lo;

  // Row bounds, in-pair successor and entry row of the following pair.
  always_comb begin
    w_row_end    = 5'd0;
    w_row_next   = 5'd0;
    w_next_start = 5'd0;
    if (w_up) begin
      w_row_end  = w_full ? 5'd20 : 5'd11;
      w_row_next = (w_full && r_row == 5'd13) ? 5'd15 : r_row + 5'd1;
    end else begin
      w_row_end  = w_full ? 5'd12 : 5'd0;
      w_row_next = (w_full && r_row == 5'd15) ? 5'd13 : r_row - 5'd1;
    end
    if (r_pair[0]) begin
      w_next_start = 5'd0;
    end else begin
      w_next_start = (r_pair == 3'd4) ? 5'd20 : 5'd11;
    end
  end

  // Advance hi -> lo within a row position, then to the next row or pair.
  always_ff @(posedge clk_in) begin
    if (rst_in || start) begin
      r_pair <= 3'd0;
      r_row  <= 5'd0;
      r_lo   <= 1'b0;
    end else if (step && !last_out) begin
      if (!r_lo) begin
        r_lo <= 1'b1;
      end else begin
        r_lo <= 1'b0;
        if (r_row == w_row_end) begin
          r_pair <= r_pair + 3'd1;
          r_row  <= w_next_start;
        end else begin
          r_row <= w_row_next;
        end
      end
    end
  end

endmodule

// File: rtl/qr_encode.sv
// rtl/qr_encode.sv - byte-mode QR v1-L data-codeword encoder and module placer
module qr_encode
  import qr_pkg::*;
(
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic [7:0]   data_in,
  input  logic         valid_in,
  input  logic         last_in,
  output logic         ready_out,
  output logic [440:0] qr_out,
  output logic [7:0]   length_out,
  output logic         busy_out,
  output logic         done_out,
  output logic         overflow_out
);

  state_t       r_state;
  logic [7:0]   r_buf [MAX_PAYLOAD];
  logic [7:0]   r_len;
  logic [7:0]   r_k;
  logic [440:0] r_grid;
  logic         r_ovf;

  logic         w_accept;
  logic         w_placing;
  logic [8:0]   w_idx;
  logic         w_last;
  logic         w_bit;
  logic [7:0]   w_pay_end;
  logic [7:0]   w_term_end;
  logic [2:0]   w_hdr_off;
  logic [7:0]   w_pay_off;
  logic [3:0]   w_pad_off;
  logic [7:0]   w_pay_byte;
  logic [7:0]   w_pad_byte;

  assign ready_out    = (r_state == ST_IDLE) || (r_state == ST_LOAD);
  assign busy_out     = (r_state != ST_IDLE);
  assign done_out     = (r_state == ST_DONE);
  assign qr_out       = r_grid;
  assign length_out   = r_len;
  assign overflow_out = r_ovf;
  assign w_accept     = valid_in && ready_out;
  assign w_placing    = (r_state == ST_PLACE);

  qr_place_cursor u_cursor (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .start    (!w_placing),
    .step     (w_placing),
    .idx_out  (w_idx),
    .last_out (w_last)
  );

  // Field boundaries: header is 12 bits, payload 8n, then a 4-bit terminator.
  assign w_pay_end  = 8'd12 + {r_len[4:0], 3'b000};
  assign w_term_end = w_pay_end + 8'd4;
  assign w_hdr_off  = r_k[2:0] - 3'd4;
  assign w_pay_off  = r_k - 8'd12;
  assign w_pad_off  = r_k[3:0] - w_term_end[3:0];
  assign w_pay_byte = r_buf[w_pay_off[7:3]];
  assign w_pad_byte = w_pad_off[3] ? PAD1 : PAD0;

  // Select the bitstream bit for position k from the field it falls in.
  always_comb begin
    w_bit = 1'b0;
    if (r_k < 8'd4) begin
      w_bit = MODE_BYTE[~r_k[1:0]];
    end else if (r_k < 8'd12) begin
      w_bit = r_len[~w_hdr_off];
    end else if (r_k < w_pay_end) begin
      w_bit = w_pay_byte[~w_pay_off[2:0]];
    end else if (r_k < w_term_end) begin
      w_bit = 1'b0;
    end else begin
      w_bit = w_pad_byte[~w_pad_off[2:0]];
    end
  end

  // Payload capture; stale entries beyond length are never read.
  always_ff @(posedge clk_in) begin
    if (w_accept) begin
      r_buf[(r_state == ST_IDLE) ? 5'd0 : r_len[4:0]] <= data_in;
    end
  end

  // Message FSM, length/overflow tracking and grid writes.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= ST_IDLE;
      r_len   <= 8'd0;
      r_k     <= 8'd0;
      r_grid  <= '0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_k <= 8'd0;
          if (w_accept) begin
            r_grid  <= '0;
            r_ovf   <= 1'b0;
            r_len   <= 8'd1;
            r_state <= last_in ? ST_PLACE : ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (w_accept) begin
            r_len <= r_len + 8'd1;
            if (last_in || r_len == 8'(MAX_PAYLOAD - 1)) begin
              r_state <= ST_PLACE;
            end
            if (!last_in && r_len == 8'(MAX_PAYLOAD - 1)) begin
              r_ovf <= 1'b1;
            end
          end
        end
        ST_PLACE: begin
          r_grid[w_idx] <= ~w_bit;
          r_k           <= r_k + 8'd1;
          if (w_last) begin
            r_state <= ST_DONE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_qr_encode.sv
// tb/tb_qr_encode.sv - self-checking bench for qr_encode
module tb_qr_encode;

  logic         clk_in = 1'b0;
  logic         rst_in;
  logic [7:0]   data_in;
  logic         valid_in;
  logic         last_in;
  logic         ready_out;
  logic [440:0] qr_out;
  logic [7:0]   length_out;
  logic         busy_out;
  logic         done_out;
  logic         overflow_out;

  int checks = 0;
  int failures = 0;
  int done_seen = 0;

  logic [7:0]   msg [0:17];
  logic [440:0] exp_grid;
  logic [7:0]   exp_len;
  logic         exp_ovf;
  bit           exp_armed = 1'b0;

  always #5 clk_in = ~clk_in;

  qr_encode dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .data_in      (data_in),
    .valid_in     (valid_in),
    .last_in      (last_in),
    .ready_out    (ready_out),
    .qr_out       (qr_out),
    .length_out   (length_out),
    .busy_out     (busy_out),
    .done_out     (done_out),
    .overflow_out (overflow_out)
  );

  task automatic check(input string name, input logic [440:0] act, input logic [440:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Bitstream from the field rules, then laid out along the column-pair table.
  function automatic void build_model(input int n, input bit ovf);
    bit q[$];
    logic [3:0] mode = 4'b0100;
    logic [7:0] ln = 8'(n);
    logic [7:0] by;
    int jhi[6] = '{20, 18, 16, 14, 12, 10};
    int i0[6]  = '{0, 11, 0, 11, 0, 20};
    int i1[6]  = '{11, 0, 11, 0, 20, 12};
    int k;
    int p;
    for (int b = 3; b >= 0; b--) q.push_back(mode[b]);
    for (int b = 7; b >= 0; b--) q.push_back(ln[b]);
    for (int i = 0; i < n; i++) begin
      by = msg[i];
      for (int b = 7; b >= 0; b--) q.push_back(by[b]);
    end
    for (int b = 0; b < 4; b++) q.push_back(1'b0);
    p = 0;
    while (q.size() < 152) begin
      by = (p % 2 == 0) ? 8'hEC : 8'h11;
      for (int b = 7; b >= 0; b--) if (q.size() < 152) q.push_back(by[b]);
      p++;
    end
    exp_grid = '0;
    k = 0;
    for (int pr = 0; pr < 6; pr++) begin
      int i = i0[pr];
      int stp = (i1[pr] >= i0[pr]) ? 1 : -1;
      bit fin = 1'b0;
      while (!fin) begin
        if (i != 14) begin
          exp_grid[i + jhi[pr] * 21]       = ~q[k];
          exp_grid[i + (jhi[pr] - 1) * 21] = ~q[k + 1];
          k += 2;
        end
        if (i == i1[pr]) fin = 1'b1;
        else i += stp;
      end
    end
    exp_len = 8'(n);
    exp_ovf = ovf;
  endfunction

  // Whenever a grid is announced complete, it must match the model.
  always @(posedge clk_in) begin
    #1;
    if (done_out) begin
      done_seen++;
      if (!exp_armed) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 required=0");
      end else begin
        check("done_grid", qr_out, exp_grid);
        check("done_length", 441'(length_out), 441'(exp_len));
        check("done_overflow", 441'(overflow_out), 441'(exp_ovf));
      end
    end
  end

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic send(input int n, input int gap, input bit use_last, input bit hold);
    for (int i = 0; i < n; i++) begin
      data_in  = msg[i];
      valid_in = 1'b1;
      last_in  = use_last && (i == n - 1);
      check("ready_before_byte", 441'(ready_out), 441'(1));
      tick();
      if (gap > 0 && i != n - 1) begin
        valid_in = 1'b0;
        repeat (gap) tick();
      end
    end
    last_in  = 1'b0;
    data_in  = 8'hFF;
    valid_in = hold;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done_out && n < 300) begin
      tick();
      n++;
    end
    check(name, 441'(n), 441'(152));
    valid_in = 1'b0;
    tick();
    check("ready_after_done", 441'(ready_out), 441'(1));
    check("busy_after_done", 441'(busy_out), 441'(0));
  endtask

  initial begin
    int seen;
    rst_in   = 1'b1;
    valid_in = 1'b0;
    last_in  = 1'b0;
    data_in  = 8'h00;
    repeat (2) tick();
    check("rst_qr", qr_out, '0);
    check("rst_len", 441'(length_out), 441'(0));
    check("rst_ready", 441'(ready_out), 441'(1));
    check("rst_busy", 441'(busy_out), 441'(0));
    check("rst_done", 441'(done_out), 441'(0));
    check("rst_ovf", 441'(overflow_out), 441'(0));
    rst_in = 1'b0;

    // Single byte 0x41.
    msg[0] = 8'h41;
    build_model(1, 1'b0);
    exp_armed = 1'b1;
    send(1, 0, 1'b1, 1'b0);
    wait_done("t1_latency");
    check("t1_len", 441'(length_out), 441'(1));
    check("t1_mode_b0", 441'(qr_out[420]), 441'(1));
    check("t1_mode_b1", 441'(qr_out[399]), 441'(0));
    check("t1_pad_ec_k24", 441'(qr_out[389]), 441'(0));
    check("t1_pad_ec_k27", 441'(qr_out[367]), 441'(1));
    check("t1_pad_11_k32", 441'(qr_out[385]), 441'(1));
    check("t1_pad_11_k35", 441'(qr_out[363]), 441'(0));
    check("t1_byte_k18", 441'(qr_out[429]), 441'(1));
    check("t1_byte_k19", 441'(qr_out[408]), 441'(0));

    // Seventeen bytes, last on the 17th.
    for (int i = 0; i < 17; i++) msg[i] = 8'(i);
    build_model(17, 1'b0);
    send(17, 0, 1'b1, 1'b0);
    wait_done("t2_latency");
    check("t2_len", 441'(length_out), 441'(17));
    check("t2_ovf", 441'(overflow_out), 441'(0));
    check("t2_final_pair", 441'(qr_out[12 + 10 * 21]), 441'(1));
    check("t2_skip_row14", 441'(qr_out[14 + 11 * 21]), 441'(0));

    // Same message with gaps and valid held high through placement.
    build_model(17, 1'b0);
    send(17, 3, 1'b1, 1'b1);
    check("t3_ready_place", 441'(ready_out), 441'(0));
    wait_done("t3_latency");
    check("t3_len", 441'(length_out), 441'(17));

    // Eighteen bytes offered without last.
    for (int i = 0; i < 18; i++) msg[i] = 8'hA0 + 8'(i);
    build_model(17, 1'b1);
    send(17, 0, 1'b0, 1'b1);
    data_in = msg[17];
    check("t4_ready_18th", 441'(ready_out), 441'(0));
    check("t4_ovf_set", 441'(overflow_out), 441'(1));
    wait_done("t4_latency");
    check("t4_len", 441'(length_out), 441'(17));
    check("t4_ovf_hold", 441'(overflow_out), 441'(1));

    // Back-to-back 0x41 then 0x42.
    msg[0] = 8'h41;
    build_model(1, 1'b0);
    send(1, 0, 1'b1, 1'b0);
    check("t6_ovf_cleared", 441'(overflow_out), 441'(0));
    check("t6a_cleared", qr_out, '0);
    wait_done("t6a_latency");
    msg[0] = 8'h42;
    build_model(1, 1'b0);
    send(1, 0, 1'b1, 1'b0);
    check("t6b_cleared", qr_out, '0);
    wait_done("t6b_latency");
    check("t6b_byte_k18", 441'(qr_out[429]), 441'(0));
    check("t6b_byte_k19", 441'(qr_out[408]), 441'(1));

    // Reset in the middle of placement.
    msg[0] = 8'h55;
    build_model(1, 1'b0);
    send(1, 0, 1'b1, 1'b0);
    repeat (50) tick();
    exp_armed = 1'b0;
    seen = done_seen;
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    check("t5_qr", qr_out, '0);
    check("t5_busy", 441'(busy_out), 441'(0));
    check("t5_ready", 441'(ready_out), 441'(1));
    check("t5_len", 441'(length_out), 441'(0));
    repeat (200) tick();
    check("t5_no_done", 441'(done_seen - seen), 441'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
